// File: rtl/uart_in_parity_if.sv
// Byte-side bundle of the parity UART receiver: result register, flags, ack.
// master: receiver drives data/flags/busy, reads data_ack; slave: consumer.
interface uart_in_parity_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output data, data_valid, parity_err,
    output frame_err, overrun, busy,
    input  data_ack
  );

  modport slave (
    input  data, data_valid, parity_err,
    input  frame_err, overrun, busy,
    output data_ack
  );
endinterface

// File: rtl/uart_in_parity.sv
// Parity UART receiver: start, parity, D0..D7 LSB first, stop; one-entry holding reg.
// Ports: clk, rst_n (sync, active-low), rx serial line, bus (master modport).
module uart_in_parity #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  input logic           rx,
  uart_in_parity_if.master bus
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HLAST = CW'((H > 0) ? H - 1 : 0);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] PARITY = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
  logic          ack;

  // An ack with nothing held is ignored.
  assign ack = bus.data_ack & valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    busy_d  = busy_q;
    if (ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) begin
          // With one clk per bit the detecting cycle is the start sample.
          if (CLKS_PER_BIT == 1) begin
            busy_d  = 1'b1;
            state_d = PARITY;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        if (cnt_q == HLAST) begin
          cnt_d = '0;
          if (rx) begin
            state_d = IDLE;
          end else begin
            busy_d  = 1'b1;
            state_d = PARITY;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          par_d   = rx;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {rx, sh_q[7:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          data_d  = sh_q;
          perr_d  = par_q ^ (^sh_q) ^ PARITY_ODD;
          ferr_d  = ~rx;
          // A same-cycle ack means the old byte was consumed: no overrun.
          ovr_d   = ack ? 1'b0 : (ovr_q | valid_q);
          valid_d = 1'b1;
          if (rx) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_in_parity.sv
// Bench for uart_in_parity: CLKS_PER_BIT=1 and =4 instances, scoreboard of commits.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_uart_in_parity;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx1 = 1'b1;
  logic rx4 = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q4[$];
  logic m_valid1 = 1'b0;
  logic m_ovr1 = 1'b0;

  uart_in_parity_if if1 ();
  uart_in_parity_if if4 ();

  uart_in_parity #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .bus(if1)
  );

  uart_in_parity #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .rx(rx4), .bus(if4)
  );

  always #5 clk = ~clk;

  // Scoreboard pop for the 1-clk-per-bit receiver.
  task automatic pop1();
    exp_t e;
    e = q1.pop_front();
    checks++;
    if (if1.data_valid !== 1'b1) begin
      errors++; $display("FAIL valid1 got %b exp 1", if1.data_valid);
    end
    checks++;
    if (if1.data !== e.d) begin
      errors++; $display("FAIL data1 got %h exp %h", if1.data, e.d);
    end
    checks++;
    if (if1.parity_err !== e.pe) begin
      errors++; $display("FAIL perr1 got %b exp %b", if1.parity_err, e.pe);
    end
    checks++;
    if (if1.frame_err !== e.fe) begin
      errors++; $display("FAIL ferr1 got %b exp %b", if1.frame_err, e.fe);
    end
    checks++;
    if (if1.overrun !== e.ov) begin
      errors++; $display("FAIL ovr1 got %b exp %b", if1.overrun, e.ov);
    end
  endtask

  task automatic send1(input logic [7:0] d, input logic pbit,
                       input logic stop, input logic ack_stop);
    logic [10:0] fr;
    exp_t e;
    fr = {stop, d, pbit, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (q1.size() > 0) pop1();
        checks++;
        if (if1.busy !== 1'b0) begin
          errors++; $display("FAIL busy1_idle got %b exp 0", if1.busy);
        end
      end else begin
        checks++;
        if (if1.busy !== 1'b1) begin
          errors++; $display("FAIL busy1_bit%0d got %b exp 1", i, if1.busy);
        end
      end
      rx1 = fr[i];
      if1.data_ack = (i == 10) && ack_stop;
    end
    e.d  = d;
    e.pe = pbit ^ (^d);
    e.fe = ~stop;
    e.ov = ack_stop ? 1'b0 : (m_ovr1 | m_valid1);
    m_valid1 = 1'b1;
    m_ovr1 = e.ov;
    q1.push_back(e);
  endtask

  task automatic finish1();
    @(negedge clk);
    rx1 = 1'b1;
    if1.data_ack = 1'b0;
    if (q1.size() > 0) pop1();
    checks++;
    if (if1.busy !== 1'b0) begin
      errors++; $display("FAIL busy1_end got %b exp 0", if1.busy);
    end
  endtask

  task automatic ack1();
    @(negedge clk);
    rx1 = 1'b1;
    if1.data_ack = 1'b1;
    m_valid1 = 1'b0;
    m_ovr1 = 1'b0;
    @(negedge clk);
    if1.data_ack = 1'b0;
    checks++;
    if (if1.data_valid !== 1'b0 || if1.overrun !== 1'b0) begin
      errors++;
      $display("FAIL ack1 got v=%b o=%b exp v=0 o=0",
               if1.data_valid, if1.overrun);
    end
  endtask

  task automatic send4(input logic [7:0] d, input logic pbit,
                       input logic stop, input int rst_at);
    logic [10:0] fr;
    exp_t e;
    fr = {stop, d, pbit, 1'b0};
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (rst_at >= 0 && i * 4 + c == rst_at + 1) begin
          checks++;
          if (if4.busy !== 1'b0 || if4.data_valid !== 1'b0 ||
              if4.data !== 8'h00) begin
            errors++;
            $display("FAIL rst4_mid got b=%b v=%b d=%h exp 0/0/00",
                     if4.busy, if4.data_valid, if4.data);
          end
        end
        rst_n = (i * 4 + c == rst_at) ? 1'b0 : 1'b1;
        rx4 = fr[i];
      end
    end
    if (rst_at < 0) begin
      e.d  = d;
      e.pe = pbit ^ (^d);
      e.fe = ~stop;
      e.ov = 1'b0;
      q4.push_back(e);
    end
  endtask

  task automatic finish4();
    exp_t e;
    @(negedge clk);
    rx4 = 1'b1;
    rst_n = 1'b1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checks++;
      if (if4.data_valid !== 1'b1 || if4.data !== e.d) begin
        errors++;
        $display("FAIL frame4 got v=%b d=%h exp v=1 d=%h",
                 if4.data_valid, if4.data, e.d);
      end
      checks++;
      if (if4.parity_err !== e.pe || if4.frame_err !== e.fe ||
          if4.overrun !== e.ov) begin
        errors++;
        $display("FAIL flags4 got p=%b f=%b o=%b exp p=%b f=%b o=%b",
                 if4.parity_err, if4.frame_err, if4.overrun,
                 e.pe, e.fe, e.ov);
      end
    end else begin
      checks++;
      if (if4.data_valid !== 1'b0 || if4.busy !== 1'b0) begin
        errors++;
        $display("FAIL idle4 got v=%b b=%b exp 0/0",
                 if4.data_valid, if4.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (if1.data !== 8'h00 || if1.data_valid !== 1'b0 ||
        if1.parity_err !== 1'b0 || if1.frame_err !== 1'b0 ||
        if1.overrun !== 1'b0 || if1.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset1 got d=%h v=%b p=%b f=%b o=%b b=%b exp all 0",
               if1.data, if1.data_valid, if1.parity_err,
               if1.frame_err, if1.overrun, if1.busy);
    end
    checks++;
    if (if4.data !== 8'h00 || if4.data_valid !== 1'b0 ||
        if4.overrun !== 1'b0 || if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset4 got d=%h v=%b o=%b b=%b exp all 0",
               if4.data, if4.data_valid, if4.overrun, if4.busy);
    end
  endtask

  task automatic test_basic();
    send1(8'hA5, 1'b0, 1'b1, 1'b0);
    finish1();
    ack1();
  endtask

  task automatic test_parity_err();
    send1(8'h01, 1'b0, 1'b1, 1'b0);
    finish1();
    ack1();
  endtask

  task automatic test_frame_err();
    send1(8'h3C, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) pop1();
      rx1 = 1'b0;
      if1.data_ack = 1'b0;
      checks++;
      if (if1.busy !== 1'b1) begin
        errors++; $display("FAIL busy1_break%0d got %b exp 1", k, if1.busy);
      end
    end
    @(negedge clk);
    rx1 = 1'b1;
    checks++;
    if (if1.busy !== 1'b1) begin
      errors++; $display("FAIL busy1_brk_end got %b exp 1", if1.busy);
    end
    @(negedge clk);
    checks++;
    if (if1.busy !== 1'b0) begin
      errors++; $display("FAIL busy1_brk_idle got %b exp 0", if1.busy);
    end
    ack1();
    send1(8'h55, 1'b0, 1'b1, 1'b0);
    finish1();
    ack1();
  endtask

  task automatic test_back_to_back();
    send1(8'h11, 1'b0, 1'b1, 1'b0);
    send1(8'h22, 1'b0, 1'b1, 1'b0);
    finish1();
    ack1();
    send1(8'h11, 1'b0, 1'b1, 1'b0);
    send1(8'h22, 1'b0, 1'b1, 1'b1);
    finish1();
    ack1();
  endtask

  task automatic test_glitch4();
    @(negedge clk);
    rx4 = 1'b0;
    @(negedge clk);
    rx4 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (if4.busy !== 1'b0 || if4.data_valid !== 1'b0) begin
        errors++;
        $display("FAIL glitch4_%0d got b=%b v=%b exp 0/0",
                 k, if4.busy, if4.data_valid);
      end
    end
  endtask

  task automatic test_reset4();
    send4(8'hF8, 1'b1, 1'b1, 21);
    m_valid1 = 1'b0;
    m_ovr1 = 1'b0;
    finish4();
    send4(8'h81, 1'b0, 1'b1, -1);
    finish4();
  endtask

  initial begin
    if1.data_ack = 1'b0;
    if4.data_ack = 1'b0;
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_back_to_back();
    test_glitch4();
    test_reset4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_in_parity.md
Name: uart_in_parity

Overview:
- Serial receiver that consumes the frame stream produced by the team's parity-protected UART transmitter (uart_out).
- Deserialises each frame into a byte, checks parity and the stop bit, and presents the result through a one-entry valid/ack holding register.
- Sits downstream of uart_out on the serial line, or at the board RX pin, and feeds byte-level consumers.
- Frame order on the line, first to last: start(0), parity, D0..D7 (LSB first), stop(1). Eleven bit periods total.

Parameters:
- CLKS_PER_BIT, 1: clk cycles per bit period. 1 matches uart_out, which sends one bit per clk. Legal values are ≥1.
- PARITY_ODD, 0: 0 selects even parity (parity bit = XOR of D7..D0); 1 selects odd parity (its inverse).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- rx  in  1  serial line, same clock domain as clk, idles high
- data_ack  in  1  consumer pulse; clears data_valid
- data  out  8  received byte, held until the next frame completes
- data_valid  out  1  level; set when a frame completes, cleared by data_ack
- parity_err  out  1  parity mismatch for the byte in data; updated together with data
- frame_err  out  1  stop bit sampled 0 for the byte in data; updated together with data
- overrun  out  1  sticky; a frame completed while data_valid=1. Cleared only by data_ack or reset
- busy  out  1  1 from start-bit acceptance until return to IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; data=0; data_valid, parity_err, frame_err, overrun and busy all 0; counters 0.
  - Applies mid-frame too: the partial frame is discarded and no valid is produced.
- Let H = CLKS_PER_BIT/2 (integer division); H=0 when CLKS_PER_BIT=1.
- States:
  - IDLE: when rx=0, go to START with the cycle counter at 0.
  - START: after H further cycles, sample rx. If 1, treat as a glitch and return to IDLE with no outputs changed. If 0, set busy=1 and go to PARITY. For CLKS_PER_BIT=1, the IDLE cycle that sees rx=0 is itself the start sample.
  - PARITY: sample rx CLKS_PER_BIT cycles after the start sample; store it; go to DATA.
  - DATA: take 8 samples spaced CLKS_PER_BIT apart and shift them in LSB first using a 3-bit bit index; after D7 go to STOP.
  - STOP: sample rx one bit period after D7, then commit:
    - data ← shift register;
    - parity_err ← (received parity ≠ expected parity);
    - frame_err ← ~rx;
    - overrun ← overrun | data_valid;
    - data_valid ← 1.
    - Then go to IDLE if stop=1, or to BREAK if stop=0.
  - BREAK: wait for rx=1, then go to IDLE. busy stays 1 in this state.
- Latency:
  - With CLKS_PER_BIT=1 and the start sample at cycle t0: parity at t0+1, D0..D7 at t0+2..t0+9, stop at t0+10.
  - data_valid and the error flags are visible at t0+11.
  - busy=1 from t0+1 to t0+10, back to 0 at t0+11.
  - Back-to-back frames are accepted: IDLE at t0+11 may take a new start on that same cycle.
- Errors:
  - A parity error still delivers the byte, with parity_err=1.
  - Error flags are not sticky; each commit overwrites them.
- Simultaneous events:
  - data_ack and a commit in the same cycle: the commit wins. data_valid stays 1, the new data is loaded, and overrun is not set because the old byte was consumed.
  - data_ack while data_valid=0: no effect.
- Overrun: a commit while data_valid=1 without ack overwrites data, sets overrun=1, and keeps data_valid=1.
- Counters: the cycle counter width is clog2(CLKS_PER_BIT) bits, minimum 1 bit. It resets to 0 on every sample and never wraps mid-bit.

Test Plan:
- 0xA5, even parity, CLKS_PER_BIT=1: drive rx sequence 0,0,1,0,1,0,0,1,0,1,1 starting at t0 → data_valid=1 at t0+11, data=0xA5, parity_err=0, frame_err=0, busy high t0+1..t0+10.
- Parity error: 0x01 sent with parity bit 0 → data=0x01, data_valid=1, parity_err=1, frame_err=0.
- Frame error: 0x3C, correct parity, stop=0, rx held low 5 more cycles → frame_err=1 and busy stays 1 until rx=1; a following 0x55 frame is received cleanly.
- Overrun/ack: two back-to-back frames 0x11 then 0x22 with no ack → data=0x22, overrun=1. data_ack → data_valid=0, overrun=0. Repeat with data_ack on the second frame's commit cycle → data_valid=1, overrun=0.
- Glitch and reset, CLKS_PER_BIT=4: a 1-cycle low pulse on rx → no busy, no valid. Then rst_n=0 for 1 cycle during D3 of a frame → all outputs 0, and the next full 0x81 frame is received correctly.
